// File: rtl/cs_pkg.sv
// Shared widths, sample type and the x9 helper for the approximate-average filter.
package cs_pkg;

    localparam int N_WIN = 9;
    localparam int W_X   = 8;
    localparam int W_Y   = 10;
    localparam int W_SUM = 12;
    localparam int W_ACC = 13;

    typedef logic [W_X-1:0] sample_t;

    // 9*x as a shift-and-add; 9*255 = 2295 still fits the sum width.
    function automatic logic [W_SUM-1:0] times9(sample_t x);
        logic [W_SUM-1:0] wide;
        wide   = W_SUM'(x);
        times9 = (wide << 3) + wide;
    endfunction

endpackage

// File: rtl/cs_if.sv
// Sample/result stream between the producer and the cs_unit filter stage.
interface cs_if;
    import cs_pkg::*;

    sample_t          X;
    logic [W_Y-1:0]   Y;

    modport master (output X, input Y);
    modport slave  (input X, output Y);

endinterface

// File: rtl/cs_appr.sv
// Picks the largest window sample whose ninefold value does not exceed the window sum.
module cs_appr
    import cs_pkg::*;
(
    input  sample_t            win [N_WIN],
    input  logic [W_SUM-1:0]   sum,
    output sample_t            appr
);

    localparam int N_PAD = 16;

    sample_t cand [N_PAD];

    function automatic sample_t max2(sample_t a, sample_t b);
        return (a > b) ? a : b;
    endfunction

    // NOTE: every element gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < N_PAD; i++) begin
            cand[i] = '0;
        end
        for (int i = 0; i < N_WIN; i++) begin
            if (times9(win[i]) <= sum) begin
                cand[i] = win[i];
            end
        end
        // Balanced in-place reduction: each level reads indices at or above the one it writes.
        for (int step = N_PAD / 2; step >= 1; step = step / 2) begin
            for (int i = 0; i < step; i++) begin
                cand[i] = max2(cand[2*i], cand[2*i+1]);
            end
        end
        appr = cand[0];
    end

endmodule

// File: rtl/cs_unit.sv
// Sliding nine-sample approximate-average filter with a single registered output stage.
module cs_unit
    import cs_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    cs_if.slave   bus
);

    sample_t            hist [1:N_WIN-1];
    sample_t            win  [N_WIN];
    logic [W_SUM-1:0]   sum;
    sample_t            appr;
    logic [W_ACC-1:0]   acc;
    logic [W_Y-1:0]     y_q;

    always_comb begin
        win[0] = bus.X;
        for (int k = 1; k < N_WIN; k++) begin
            win[k] = hist[k];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_WIN; i++) begin
            sum = sum + W_SUM'(win[i]);
        end
    end

    cs_appr u_appr (
        .win  (win),
        .sum  (sum),
        .appr (appr)
    );

    assign acc = W_ACC'(sum) + W_ACC'(times9(appr));

    // NOTE: the history is a handful of flops, not a RAM, so it is cleared on reset to give zero-filled windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k < N_WIN; k++) begin
                hist[k] <= '0;
            end
            y_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage shift from the pre-edge values.
            hist[1] <= bus.X;
            for (int k = 2; k < N_WIN; k++) begin
                hist[k] <= hist[k-1];
            end
            y_q <= acc[W_ACC-1:3];
        end
    end

    assign bus.Y = y_q;

endmodule

// File: tb/tb_cs_unit.sv
// Directed vector table for the documented cases plus a randomized run against a window model.
module tb_cs_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cs_if bus ();

    cs_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [7:0]  x;
        bit          chk;
        int          exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Reference history: the last eight captured samples, newest first.
    int hq[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add(input bit rst, input int x, input bit chk, input int exp, input string name);
        vec_t v;
        v.rst  = rst;
        v.x    = 8'(x);
        v.chk  = chk;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < 8; i++) hq.push_back(0);
    endtask

    // Result for window {x, hq}: exact average rule, then (S + 9*appr) / 8.
    function automatic int model_step(input int x);
        int w[9];
        int s;
        int best;
        w[0] = x;
        for (int i = 0; i < 8; i++) w[i+1] = hq[i];
        s = 0;
        foreach (w[i]) s += w[i];
        best = 0;
        foreach (w[i]) if (9 * w[i] <= s && w[i] > best) best = w[i];
        return (s + 9 * best) / 8;
    endfunction

    task automatic apply(input bit rst, input int x);
        reset = rst;
        bus.X = 8'(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ramp_exp [8];
        int k50_exp [8];
        int base;
        int x;
        int exp;
        bit rst;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.X  = '0;

        // Reset state, then a constant 100 stream filling the window.
        add(1, 0, 1, 0, "reset_y");
        ramp_exp = '{12, 25, 37, 50, 62, 75, 87, 100};
        for (int k = 0; k < 8; k++) add(0, 100, 1, ramp_exp[k], "fill_100");
        add(0, 100, 1, 225, "const_100");
        add(0, 100, 1, 225, "const_100_hold");

        for (int k = 0; k < 8; k++) add(0, 255, 0, 0, "");
        add(0, 255, 1, 573, "all_255");
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, "");
        add(0, 0, 1, 0, "all_0");

        for (int k = 1; k <= 8; k++) add(0, k, 0, 0, "");
        add(0, 9, 1, 11, "ramp_1_9");

        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, "");
        add(0, 10, 1, 1, "nonint_10");
        add(0, 20, 1, 3, "nonint_20");

        // Mid-stream reset with a nonzero X that must be ignored.
        for (int k = 0; k < 9; k++) add(0, 100, 0, 0, "");
        add(0, 100, 1, 225, "pre_reset_100");
        add(1, 77, 1, 0, "mid_reset_1");
        add(1, 77, 1, 0, "mid_reset_2");
        k50_exp = '{6, 12, 18, 25, 31, 37, 43, 50};
        for (int k = 0; k < 8; k++) add(0, 50, 1, k50_exp[k], "refill_50");
        add(0, 50, 1, 112, "steady_50");

        foreach (vecs[i]) begin
            apply(vecs[i].rst, int'(vecs[i].x));
            if (vecs[i].chk) check(vecs[i].name, int'(bus.Y), vecs[i].exp);
        end

        // Randomized regression: clustered and wide samples, occasional resets.
        apply(1, 0);
        model_reset();
        base = 120;
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 31) == 0) base = $urandom_range(0, 240);
            if ($urandom_range(0, 2) == 0) x = $urandom_range(0, 255);
            else                           x = base + $urandom_range(0, 15);
            if (rst) begin
                exp = 0;
                model_reset();
            end else begin
                exp = model_step(x);
                void'(hq.pop_back());
                hq.push_front(x);
            end
            apply(rst, x);
            check("random", int'(bus.Y), exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
